serial_transmitter: RTL and testbench

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

---
 rtl/serial_pkg.sv | 18 +
 rtl/bit_timer.sv | 22 ++
 rtl/serial_transmitter.sv | 81 ++++++++
 tb/tb_serial_transmitter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding, widths and parity modes for the serial link
package serial_pkg;
  localparam int CLKS_PER_BIT_DEF = 5028;
  localparam int DATA_W = 8;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input int mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction
endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts one serial bit period and flags its final cycle
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] count;
  assign tick = enable && count == LAST;
  // advance through the period, wrapping to zero on its last cycle
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) count <= '0;
    else if (clear || tick) count <= '0;
    else if (enable) count <= count + 1'b1;
endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: buffered 8-bit serial framer with optional parity
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY = PARITY_NONE
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  output logic       TxReady,
  output logic       TxBusy,
  output logic       SerialOut,
  output logic       TxDone
);
  tx_state_t state, state_next;
  logic [DATA_W-1:0] hold, shift;
  logic hold_full, tick, load, last_bit, line_next;
  logic [2:0] bit_idx;
  assign TxReady = !hold_full;
  assign TxBusy = state != ST_IDLE;
  assign TxDone = state == ST_STOP && tick;
  assign last_bit = bit_idx == 3'd7;
  assign load = hold_full && (state == ST_IDLE || TxDone);
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .Clock(Clock),
    .Reset(Reset),
    .enable(TxBusy),
    .clear(!TxBusy),
    .tick(tick)
  );
  // frame sequencing; a full buffer at stop chains straight into the next start
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (hold_full) state_next = ST_START;
      ST_START:  if (tick) state_next = ST_DATA;
      ST_DATA:   if (tick && last_bit) state_next = PARITY != PARITY_NONE ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_next = ST_STOP;
      ST_STOP:   if (tick) state_next = hold_full ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end
  // line level for the current state, registered one cycle later
  always_comb begin
    line_next = 1'b1;
    case (state)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = shift[bit_idx];
      ST_PARITY: line_next = parity_bit(shift, PARITY);
      default:   line_next = 1'b1;
    endcase
  end
  // state and glitch-free line register
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state <= ST_IDLE;
      SerialOut <= 1'b1;
    end else begin
      state <= state_next;
      SerialOut <= line_next;
    end
  // holding buffer: filled by an accepted request, drained into the shift register
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      hold <= '0;
      hold_full <= 1'b0;
      shift <= '0;
    end else if (load) begin
      shift <= hold;
      hold_full <= 1'b0;
    end else if (TxStart && !hold_full) begin
      hold <= TxData;
      hold_full <= 1'b1;
    end
  // data bit index, wrapping back to 0 as the last data bit ends
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) bit_idx <= '0;
    else if (state == ST_DATA && tick) bit_idx <= bit_idx + 3'd1;
endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: frame-level reference model check of four transmitter configurations
module tb_serial_transmitter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic [N-1:0] rst_n = '1;
  logic [N-1:0] start = '0;
  logic [7:0] data [N];
  logic [N-1:0] ready, busy, line, done;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit m_full [N];
  bit m_busy [N];
  bit cur_v [N];
  bit prv_v [N];
  int cur_s [N];
  int prv_s [N];
  logic [7:0] m_buf [N];
  logic [7:0] cur_d [N];
  logic [7:0] prv_d [N];
  logic [9:0] a5_exp = 10'b1101001010;
  logic [9:0] c3_exp = 10'b1001111000;

  always #5 clk = ~clk;

  serial_transmitter #(.CLKS_PER_BIT(4), .PARITY(0)) dut0 (
    .Clock(clk), .Reset(rst_n[0]), .TxData(data[0]), .TxStart(start[0]),
    .TxReady(ready[0]), .TxBusy(busy[0]), .SerialOut(line[0]), .TxDone(done[0]));
  serial_transmitter #(.CLKS_PER_BIT(4), .PARITY(1)) dut1 (
    .Clock(clk), .Reset(rst_n[1]), .TxData(data[1]), .TxStart(start[1]),
    .TxReady(ready[1]), .TxBusy(busy[1]), .SerialOut(line[1]), .TxDone(done[1]));
  serial_transmitter #(.CLKS_PER_BIT(4), .PARITY(2)) dut2 (
    .Clock(clk), .Reset(rst_n[2]), .TxData(data[2]), .TxStart(start[2]),
    .TxReady(ready[2]), .TxBusy(busy[2]), .SerialOut(line[2]), .TxDone(done[2]));
  serial_transmitter dut3 (
    .Clock(clk), .Reset(rst_n[3]), .TxData(data[3]), .TxStart(start[3]),
    .TxReady(ready[3]), .TxBusy(busy[3]), .SerialOut(line[3]), .TxDone(done[3]));

  function automatic int cpb(input int i);
    return i == 3 ? 5028 : 4;
  endfunction
  function automatic int par(input int i);
    return i == 1 ? 1 : (i == 2 ? 2 : 0);
  endfunction
  function automatic int nbits(input int i);
    return par(i) != 0 ? 11 : 10;
  endfunction
  function automatic int flen(input int i);
    return nbits(i) * cpb(i);
  endfunction
  // bit n of a frame: start, eight data bits LSB first, optional parity, stop
  function automatic logic fbit(input logic [7:0] d, input int p, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    if (n == 9 && p != 0) return (($countones(d) % 2) == 1) == (p == 1);
    return 1'b1;
  endfunction
  function automatic logic exp_line(input int i);
    if (cur_v[i] && cyc > cur_s[i] && cyc <= cur_s[i] + flen(i))
      return fbit(cur_d[i], par(i), (cyc - cur_s[i] - 1) / cpb(i));
    if (prv_v[i] && cyc > prv_s[i] && cyc <= prv_s[i] + flen(i))
      return fbit(prv_d[i], par(i), (cyc - prv_s[i] - 1) / cpb(i));
    return 1'b1;
  endfunction

  // reference model: one-byte queue feeding whole frames of known length
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n[i]) begin
        m_full[i] = 0;
        m_busy[i] = 0;
        cur_v[i] = 0;
        prv_v[i] = 0;
      end else begin
        bit acc;
        acc = start[i] && !m_full[i];
        if (m_busy[i] && cyc == cur_s[i] + flen(i)) m_busy[i] = 0;
        if (!m_busy[i] && m_full[i]) begin
          prv_v[i] = cur_v[i];
          prv_s[i] = cur_s[i];
          prv_d[i] = cur_d[i];
          cur_v[i] = 1;
          cur_s[i] = cyc;
          cur_d[i] = m_buf[i];
          m_busy[i] = 1;
          m_full[i] = 0;
        end
        if (acc) begin
          m_full[i] = 1;
          m_buf[i] = data[i];
        end
      end
    end
  end

  task automatic cmp(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %b want %b", name, i, cyc, act, exp);
    end
  endtask
  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // per-cycle comparison of every DUT against the model
  always @(negedge clk)
    for (int i = 0; i < N; i++) begin
      cmp("SerialOut", i, line[i], rst_n[i] ? exp_line(i) : 1'b1);
      cmp("TxReady", i, ready[i], rst_n[i] ? !m_full[i] : 1'b1);
      cmp("TxBusy", i, busy[i], rst_n[i] ? m_busy[i] : 1'b0);
      cmp("TxDone", i, done[i], rst_n[i] && m_busy[i] && cyc == cur_s[i] + flen(i) - 1);
    end

  task automatic send(input int i, input logic [7:0] d);
    start[i] = 1'b1;
    data[i] = d;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  // observe one frame from the cycle a request was accepted
  task automatic capture(input int i, output logic [10:0] bits, output int done_n,
                         output int done_cnt, output int busy_cnt, output int first_low,
                         output int low_cnt);
    int c;
    int nb;
    c = cpb(i);
    nb = nbits(i);
    bits = '1;
    done_n = -1;
    done_cnt = 0;
    busy_cnt = 0;
    first_low = -1;
    low_cnt = 0;
    for (int n = 0; n < nb * c + 6; n++) begin
      @(negedge clk);
      if (n >= 2 && (n - 2) % c == c / 2 && (n - 2) / c < nb) bits[(n - 2) / c] = line[i];
      if (done[i]) begin
        done_cnt++;
        done_n = n;
      end
      if (busy[i]) busy_cnt++;
      if (!line[i]) begin
        low_cnt++;
        if (first_low < 0) first_low = n;
      end
    end
  endtask

  initial begin
    logic [10:0] bits, d_bits;
    int dn, dc, bc, fl, lc, w, t1, t2;
    int d_dn, d_dc, d_bc, d_fl, d_lc;
    logic bafter;
    for (int i = 0; i < N; i++) data[i] = '0;
    #1 rst_n = '0;
    lit("model even parity 07", fbit(8'h07, 1, 9), 1);
    lit("model odd parity 07", fbit(8'h07, 2, 9), 0);
    lit("model parity frame length", flen(1), 44);
    repeat (3) @(posedge clk);
    #1 rst_n = '1;
    fork
      begin
        send(3, 8'h00);
        capture(3, d_bits, d_dn, d_dc, d_bc, d_fl, d_lc);
        lit("slow start latency", d_fl, 2);
        lit("slow low cycles", d_lc, 9 * 5028);
        lit("slow done cycle", d_dn, 50280);
        lit("slow busy cycles", d_bc, 50280);
      end
      begin
        send(0, 8'hA5);
        capture(0, bits, dn, dc, bc, fl, lc);
        for (int b = 0; b < 10; b++) lit($sformatf("A5 bit %0d", b), bits[b], a5_exp[b]);
        lit("A5 start latency", fl, 2);
        lit("A5 done cycle", dn, 40);
        lit("A5 done count", dc, 1);
        lit("A5 busy cycles", bc, 40);
        send(0, 8'h55);
        w = 0;
        while (!ready[0] && w < 10) begin
          @(posedge clk);
          #1 w++;
        end
        lit("queue window ready", ready[0], 1);
        send(0, 8'h0F);
        send(0, 8'hFF);
        t1 = -1;
        t2 = -1;
        dc = 0;
        bafter = 1'b0;
        for (int n = 0; n < 140; n++) begin
          @(negedge clk);
          if (t1 >= 0 && n == t1 + 1) bafter = busy[0];
          if (done[0]) begin
            dc++;
            if (t1 < 0) t1 = n;
            else t2 = n;
          end
        end
        lit("b2b done count", dc, 2);
        lit("b2b done spacing", t2 - t1, 40);
        lit("b2b busy after first done", bafter, 1);
        send(0, 8'hF0);
        w = 0;
        while (!ready[0] && w < 10) begin
          @(posedge clk);
          #1 w++;
        end
        send(0, 8'h99);
        repeat (16) @(posedge clk);
        #1 rst_n[0] = 1'b0;
        @(negedge clk);
        lit("reset SerialOut", line[0], 1);
        lit("reset TxReady", ready[0], 1);
        lit("reset TxBusy", busy[0], 0);
        lit("reset TxDone", done[0], 0);
        repeat (2) @(posedge clk);
        #1 rst_n[0] = 1'b1;
        send(0, 8'h3C);
        capture(0, bits, dn, dc, bc, fl, lc);
        for (int b = 0; b < 10; b++) lit($sformatf("3C bit %0d", b), bits[b], c3_exp[b]);
        lit("3C done count", dc, 1);
        lit("3C busy cycles", bc, 40);
        send(1, 8'h07);
        capture(1, bits, dn, dc, bc, fl, lc);
        lit("even parity bit", bits[9], 1);
        lit("even stop bit", bits[10], 1);
        lit("even frame done", dn, 44);
        send(2, 8'h07);
        capture(2, bits, dn, dc, bc, fl, lc);
        lit("odd parity bit", bits[9], 0);
        lit("odd frame done", dn, 44);
        for (int blk = 0; blk < 15; blk++) begin
          int dens;
          dens = $urandom_range(1, 8);
          repeat (100) begin
            for (int i = 0; i < 3; i++) begin
              start[i] = $urandom_range(0, 7) < dens;
              data[i] = 8'($urandom);
              rst_n[i] = $urandom_range(0, 299) != 0;
            end
            @(posedge clk);
            #1;
          end
        end
        for (int i = 0; i < 3; i++) begin
          start[i] = 1'b0;
          rst_n[i] = 1'b1;
        end
        repeat (60) @(posedge clk);
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
